// File: rtl/main_memory_pkg.sv
// Shared constants and FSM encoding for the block-fetch main memory.
package main_memory_pkg;

  localparam int ADDR_W          = 15;
  localparam int DATA_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int OFFSET_W        = 2;

  typedef enum logic [1:0] {
    MM_IDLE  = 2'd0,
    MM_WAIT  = 2'd1,
    MM_BURST = 2'd2,
    MM_VALID = 2'd3
  } mm_state_e;

endpackage

// File: rtl/mm_wait_counter.sv
// 8-bit load/decrement counter with zero flag; times the access latency of a fetch.
module mm_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/main_memory_block_fetch.sv
// 32K x 32 backing store returning an aligned 4-word block after a fixed latency.
// Define MM_STATS_EN to add the fetch_count / drop_count statistics outputs.
module main_memory_block_fetch
  import main_memory_pkg::*;
#(
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] MMToCache0,
  output logic [DATA_W-1:0] MMToCache1,
  output logic [DATA_W-1:0] MMToCache2,
  output logic [DATA_W-1:0] MMToCache3
`ifdef MM_STATS_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       drop_count
`endif
);

  localparam int         BLK_W     = ADDR_W - OFFSET_W;
  localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("main_memory_block_fetch: LATENCY must be in 1..255");
  end

  logic [DATA_W-1:0]   r_mem [2**ADDR_W];
  mm_state_e           r_state;
  logic [BLK_W-1:0]    r_blk;
  logic [OFFSET_W-1:0] r_word;
  logic [DATA_W-1:0]   r_words [WORDS_PER_BLOCK];
  logic                r_busy;
  logic                r_valid;
  logic                w_accept;
  logic                w_wait_dec;
  logic                w_wait_zero;
  logic                w_unused_offset;

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] = '0;
  end

  // Word-in-block bits never select anything: the whole aligned block is returned.
  assign w_unused_offset = ^address[OFFSET_W-1:0];
  assign w_accept        = (r_state == MM_IDLE) && req;
  assign w_wait_dec      = (r_state == MM_WAIT) && !w_wait_zero;

  mm_wait_counter u_wait_counter (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_accept),
    .i_load_val (WAIT_LOAD),
    .i_dec      (w_wait_dec),
    .o_zero     (w_wait_zero)
  );

  // NOTE: the memory array has no reset; only control state and output registers are cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MM_IDLE;
      r_blk   <= '0;
      r_word  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) r_words[i] <= '0;
    end else begin
      case (r_state)
        MM_IDLE: begin
          if (req) begin
            r_blk   <= address[ADDR_W-1:OFFSET_W];
            r_busy  <= 1'b1;
            r_state <= MM_WAIT;
          end
        end
        MM_WAIT: begin
          if (w_wait_zero) begin
            r_word  <= '0;
            r_state <= MM_BURST;
          end
        end
        MM_BURST: begin
          r_words[r_word] <= r_mem[{r_blk, r_word}];
          r_word          <= r_word + 1'b1;
          if (r_word == OFFSET_W'(WORDS_PER_BLOCK - 1)) begin
            r_valid <= 1'b1;
            r_state <= MM_VALID;
          end
        end
        MM_VALID: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= MM_IDLE;
        end
        default: r_state <= MM_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign valid      = r_valid;
  assign MMToCache0 = r_words[0];
  assign MMToCache1 = r_words[1];
  assign MMToCache2 = r_words[2];
  assign MMToCache3 = r_words[3];

`ifdef MM_STATS_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (r_state == MM_VALID) r_fetch_count <= r_fetch_count + 16'd1;
      if (req && (r_state != MM_IDLE)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign drop_count  = r_drop_count;
`endif

endmodule

// File: tb/tb_main_memory_block_fetch.sv
// Scoreboard bench for main_memory_block_fetch: expected blocks queued at request, checked on valid.
module tb_main_memory_block_fetch;
  import main_memory_pkg::*;

  localparam int LATENCY = 4;
  localparam int PERIOD  = LATENCY + 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] mm0, mm1, mm2, mm3;
`ifdef MM_STATS_EN
  logic [15:0]       fetch_count;
  logic [15:0]       drop_count;
`endif

  main_memory_block_fetch #(.LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .address    (address),
    .busy       (busy),
    .valid      (valid),
    .MMToCache0 (mm0),
    .MMToCache1 (mm1),
    .MMToCache2 (mm2),
    .MMToCache3 (mm3)
`ifdef MM_STATS_EN
    ,
    .fetch_count(fetch_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [3:0][31:0] w;
    int               accept;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [int];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [31:0] val);
    model_mem[int'(a)] = val;
    dut.r_mem[a] = val;
  endtask

  function automatic logic [31:0] exp_word(input logic [14:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'd0;
  endfunction

  task automatic push_expect(input logic [14:0] a, input int accept);
    exp_t        e;
    logic [14:0] base;
    base = {a[14:2], 2'b00};
    for (int k = 0; k < 4; k++) e.w[k] = exp_word(base + 15'(k));
    e.accept = accept;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a single-cycle request; the accepting edge is the next posedge.
  task automatic fetch(input logic [14:0] a);
    @(negedge clk);
    req     = 1'b1;
    address = a;
    push_expect(a, cyc + 1);
    @(negedge clk);
    req     = 1'b0;
    address = 15'h5555;
  endtask

  task automatic wait_idle(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    check("done_in_time", 32'(i < max), 32'd1);
  endtask

  task automatic check_block(input string tag, input logic [3:0][31:0] w);
    check({tag, "_w0"}, mm0, w[0]);
    check({tag, "_w1"}, mm1, w[1]);
    check({tag, "_w2"}, mm2, w[2]);
    check({tag, "_w3"}, mm3, w[3]);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("req_to_valid", 32'(cyc - e.accept + 1), 32'(LATENCY + 5));
          check_block("valid", e.w);
        end
      end
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", 32'(busy_run), 32'(LATENCY + 5));
        busy_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] blk_a;
    logic [3:0][31:0] blk_top;
    logic [3:0][31:0] zero_blk;
    blk_a    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    blk_top  = {32'd4, 32'd3, 32'd2, 32'd1};
    zero_blk = '0;

    #23;
    for (int k = 0; k < 4; k++) begin
      preload(15'h0124 + 15'(k), 32'hA0 + 32'(k));
      preload(15'h7FFC + 15'(k), 32'd1 + 32'(k));
      preload(15'h0200 + 15'(k), 32'hB0 + 32'(k));
    end

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check_block("rst", zero_blk);
`ifdef MM_STATS_EN
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick(2);

    // T1 with an ignored request (T2) injected while the first fetch is busy.
    fetch(15'h0126);
    @(negedge clk);
    req     = 1'b1;
    address = 15'h0200;
    @(negedge clk);
    req     = 1'b0;
    wait_idle(LATENCY + 20);
    tick(3);
    check_block("hold_a", blk_a);
`ifdef MM_STATS_EN
    check("t2_drop_count", 32'(drop_count), 32'd1);
    check("t1_fetch_count", 32'(fetch_count), 32'd1);
`endif

    // T3: top of memory, aligned block base.
    fetch(15'h7FFF);
    wait_idle(LATENCY + 20);
    check_block("top", blk_top);

    // T4: reset mid-burst aborts the fetch.
    fetch(15'h0200);
    tick(LATENCY + 1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check_block("abort", zero_blk);
`ifdef MM_STATS_EN
    check("abort_fetch_count", 32'(fetch_count), 32'd0);
    check("abort_drop_count", 32'(drop_count), 32'd0);
`endif
    sb.delete();
    tick(2);
    rst = 1'b1;
    tick(LATENCY + 10);
    check("post_abort_busy", 32'(busy), 32'd0);
    fetch(15'h0200);
    wait_idle(LATENCY + 20);

    // T5: request held high; one fetch per full cycle, address changes between acceptances.
    @(negedge clk);
    req     = 1'b1;
    address = 15'h0124;
    push_expect(15'h0124, cyc + 1);
    push_expect(15'h0200, cyc + 1 + PERIOD);
    push_expect(15'h7FFD, cyc + 1 + 2 * PERIOD);
    for (int k = 1; k <= 2 * PERIOD + 1; k++) begin
      @(negedge clk);
      if (k == PERIOD)              address = 15'h0200;
      else if (k == 2 * PERIOD)     address = 15'h7FFD;
      else if (k == 2 * PERIOD + 1) begin
        req     = 1'b0;
        address = 15'h0000;
      end else                      address = 15'h0000;
    end
    wait_idle(3 * PERIOD + 20);
    check_block("b2b_last", blk_top);
`ifdef MM_STATS_EN
    check("b2b_fetch_count", 32'(fetch_count), 32'd4);
    check("b2b_drop_count", 32'(drop_count), 32'(2 * (LATENCY + 5)));
`endif
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
